// File: rtl/seq_frame_pkg.sv
// seq_frame_pkg: frame states, default sync pattern and counter sizing shared by both link ends
package seq_frame_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SYNC = 2'd1, S_DATA = 2'd2, S_GAP = 2'd3} state_t;
  localparam int SYNC_W_DEF = 4;
  localparam logic [SYNC_W_DEF-1:0] SYNC_DEF = 4'b1101;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = 2;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction
endpackage

// File: rtl/seq_frame_bitcnt.sv
// seq_frame_bitcnt: loadable down-counter with enable and terminal-count flag; ports clk, rst, load, load_val, en -> cnt, tc
module seq_frame_bitcnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serializes a payload MSB-first behind a sync pattern; ports clk, rst, din/din_valid/din_ready, bit_en -> sout, busy, done
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC     = SYNC_DEF,
  parameter int                GAP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              bit_en,
  output logic              sout,
  output logic              busy,
  output logic              done
);
  localparam int CW = cnt_w(SYNC_W, DATA_W, GAP_BITS);
  localparam int FW = SYNC_W + DATA_W;
  localparam logic [CW-1:0] LD_SYNC = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] LD_DATA = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LD_GAP = CW'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
  state_t state;
  logic [FW-1:0] sh;
  logic [CW-1:0] cnt;
  logic tc, load;
  logic [CW-1:0] load_val;
  // sync and payload share one shift register; its MSB is always the next bit to emit
  always_comb begin
    load = (state == S_IDLE && din_valid) || (bit_en && tc && (state == S_SYNC || state == S_DATA));
    load_val = state == S_IDLE ? LD_SYNC : state == S_SYNC ? LD_DATA : LD_GAP;
  end
  seq_frame_bitcnt #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(bit_en), .cnt(cnt), .tc(tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      sh <= '0;
      sout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE:
          if (din_valid) begin
            sh <= {SYNC, din} << 1;
            sout <= SYNC[SYNC_W-1];
            state <= S_SYNC;
          end
        S_SYNC, S_DATA:
          if (bit_en) begin
            sout <= (tc && state == S_DATA) ? 1'b0 : sh[FW-1];
            sh <= sh << 1;
            if (tc) begin
              state <= state == S_SYNC ? S_DATA : (GAP_BITS > 0 ? S_GAP : S_IDLE);
              done <= state == S_DATA;
            end
          end
        default: if (bit_en && tc) state <= S_IDLE;
      endcase
    end
  assign din_ready = state == S_IDLE;
  assign busy = !din_ready;
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: scoreboard bench for seq_frame_tx with directed frames
module tb_seq_frame_tx;
  typedef struct packed {logic sout; logic done; logic busy;} exp_t;
  logic clk, rst, din_valid, din_ready, bit_en, sout, busy, done;
  logic [7:0] din;
  exp_t q[$];
  int cmp = 0, bad = 0, cyc = 0, ph = 0, acc = 0, acc1 = 0, det_cnt = 0, det_cyc = 0, base = 0;
  bit div4 = 0;
  logic [3:0] hist;

  seq_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC(4'b1101), .GAP_BITS(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .bit_en(bit_en), .sout(sout), .busy(busy), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ph = ph + 1;
    bit_en = div4 ? (ph % 4 == 0) : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sout", sout, e.sout);
        chk("done", done, e.done);
        chk("busy", busy, e.busy);
        chk("din_ready", din_ready, !e.busy);
      end else chk("idle_done", done, 0);
    end

  always @(posedge clk or posedge rst)
    if (rst) hist <= '0;
    else if (bit_en) begin
      hist <= {hist[2:0], sout};
      if ({hist[2:0], sout} == 4'b1101) begin
        det_cnt <= det_cnt + 1;
        det_cyc <= cyc + 1;
      end
    end

  task automatic push_frame(input logic [7:0] d, input int hold);
    logic [11:0] f;
    f = {4'b1101, d};
    for (int i = 11; i >= 0; i--)
      for (int j = 0; j < hold; j++) q.push_back('{f[i], 1'b0, 1'b1});
    for (int j = 0; j < hold; j++) q.push_back('{1'b0, j == 0, 1'b1});
    q.push_back('{1'b0, 1'b0, 1'b0});
  endtask

  task automatic send(input logic [7:0] d, input int hold, input bit keep);
    int n;
    n = 0;
    din = d;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((!din_ready || (hold > 1 && !bit_en)) && n < 200);
    if (n >= 200) chk("accept_timeout", n, 0);
    else begin
      din_valid = 1;
      @(posedge clk);
      #1;
      acc = cyc;
      push_frame(d, hold);
      if (!keep) din_valid = 0;
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    din = 0;
    din_valid = 0;
    bit_en = 1;
    #2;
    chk("rst_sout", sout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", din_ready, 1);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_sout", sout, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", din_ready, 1);
    end
    send(8'hA5, 1, 0);
    drain();
    div4 = 1;
    send(8'hFF, 4, 0);
    repeat (20) @(posedge clk);
    din = 8'h00;
    drain();
    div4 = 0;
    send(8'h3C, 1, 1);
    acc1 = acc;
    send(8'hC3, 1, 0);
    chk("b2b_period", acc - acc1, 14);
    drain();
    send(8'hF0, 1, 0);
    repeat (7) @(posedge clk);
    #3;
    chk("pre_rst_sout", sout, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    #1;
    q.delete();
    chk("abort_sout", sout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", din_ready, 1);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    base = det_cnt;
    send(8'h00, 1, 0);
    drain();
    chk("detect_count", det_cnt - base, 1);
    chk("detect_cycle", det_cyc, acc + 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
